// File: rtl/toggle_monitor_asg_pkg.sv
// Shared types and helpers for the asg toggle monitor: FSM state encoding,
// index-width helper and saturating arithmetic used by the per-net counters.
package toggle_monitor_asg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Widths up to 32 bits; the limit is computed in 33 bits so w=32 works.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= lim) return lim[31:0];
    return v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] lim;
    logic [32:0] sum;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/tgl_cnt_cell_asg.sv
// Per-net edge detector with saturating toggle counter(s).
// With ASG_TGL_SPLIT_EN defined, rise and fall are counted separately.
module tgl_cnt_cell_asg
  import toggle_monitor_asg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_cp,
  input  logic             i_cdn,
  input  logic             i_sample,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_net,
`ifdef ASG_TGL_SPLIT_EN
  output logic [CNT_W-1:0] o_rise,
`endif
  output logic [CNT_W-1:0] o_cnt
);

  logic r_prev;

  always_ff @(posedge i_cp or negedge i_cdn) begin
    if (!i_cdn) begin
      r_prev <= 1'b0;
    end else if (i_sample) begin
      r_prev <= i_net;
    end
  end

`ifdef ASG_TGL_SPLIT_EN
  logic [CNT_W-1:0] r_rise;
  logic [CNT_W-1:0] r_fall;
  logic             w_rise;
  logic             w_fall;

  assign w_rise = i_en & i_net & ~r_prev;
  assign w_fall = i_en & ~i_net & r_prev;

  always_ff @(posedge i_cp or negedge i_cdn) begin
    if (!i_cdn) begin
      r_rise <= '0;
      r_fall <= '0;
    end else if (i_clear) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      if (w_rise) r_rise <= CNT_W'(sat_inc(32'(r_rise), CNT_W));
      if (w_fall) r_fall <= CNT_W'(sat_inc(32'(r_fall), CNT_W));
    end
  end

  assign o_rise = r_rise;
  assign o_cnt  = CNT_W'(sat_add(32'(r_rise), 32'(r_fall), CNT_W));
`else
  logic [CNT_W-1:0] r_cnt;
  logic             w_toggle;

  assign w_toggle = i_en & (i_net ^ r_prev);

  always_ff @(posedge i_cp or negedge i_cdn) begin
    if (!i_cdn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (w_toggle) begin
      r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
    end
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/toggle_monitor_asg.sv
// Switching-activity monitor: counts per-net toggles over a window of CP cycles,
// then drains counts over a valid/ready port. Optional macro: ASG_TGL_SPLIT_EN.
//
// Read handshake: a word (RD_IDX, RD_CNT) is offered while RD_VALID=1 and is
// held unchanged until the rising CP edge where RD_VALID && RD_READY; RD_VALID
// never depends combinationally on RD_READY.
module toggle_monitor_asg
  import toggle_monitor_asg_pkg::*;
#(
  parameter  int NUM_NETS = 8,
  parameter  int CNT_W    = 16,
  parameter  int WIN_W    = 16,
  localparam int IDX_W    = idx_width(NUM_NETS)
) (
  input  logic                CP,
  input  logic                CDN,
  input  logic [NUM_NETS-1:0] NETS,
  input  logic                START,
  input  logic [WIN_W-1:0]    WIN_LEN,
  output logic                BUSY,
  output logic                DONE,
  output logic                RD_VALID,
  input  logic                RD_READY,
  output logic [IDX_W-1:0]    RD_IDX,
  output logic [CNT_W-1:0]    RD_CNT,
`ifdef ASG_TGL_SPLIT_EN
  output logic [CNT_W-1:0]    RD_RISE,
`endif
  output state_t              DBG_STATE
);

  state_t           r_state;
  logic [WIN_W-1:0] r_remaining;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;

  logic             w_start_idle;
  logic             w_win_zero;
  logic             w_sample;
  logic             w_en;
  logic             w_last_idx;
  logic [CNT_W-1:0] w_cnt [NUM_NETS];

  assign w_start_idle = (r_state == ST_IDLE) && START;
  assign w_win_zero   = (WIN_LEN == '0);
  // The START-cycle sample is the reference for the first compare.
  assign w_sample     = (w_start_idle && !w_win_zero) || (r_state == ST_COUNT);
  assign w_en         = (r_state == ST_COUNT);
  assign w_last_idx   = (r_idx == IDX_W'(NUM_NETS - 1));

`ifdef ASG_TGL_SPLIT_EN
  logic [CNT_W-1:0] w_rise [NUM_NETS];
`endif

  for (genvar g = 0; g < NUM_NETS; g++) begin : g_cell
    tgl_cnt_cell_asg #(
      .CNT_W(CNT_W)
    ) u_cell (
      .i_cp    (CP),
      .i_cdn   (CDN),
      .i_sample(w_sample),
      .i_clear (w_start_idle),
      .i_en    (w_en),
      .i_net   (NETS[g]),
`ifdef ASG_TGL_SPLIT_EN
      .o_rise  (w_rise[g]),
`endif
      .o_cnt   (w_cnt[g])
    );
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_idx       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_idx <= '0;
            if (w_win_zero) begin
              r_state <= ST_DRAIN;
            end else begin
              r_remaining <= WIN_LEN;
              r_state     <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          r_remaining <= r_remaining - WIN_W'(1);
          if (r_remaining == WIN_W'(1)) begin
            r_idx   <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (RD_READY) begin
            if (w_last_idx) begin
              r_idx   <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY      = (r_state != ST_IDLE);
  assign RD_VALID  = (r_state == ST_DRAIN);
  assign RD_IDX    = r_idx;
  assign RD_CNT    = RD_VALID ? w_cnt[r_idx] : '0;
  assign DONE      = r_done;
  assign DBG_STATE = r_state;
`ifdef ASG_TGL_SPLIT_EN
  assign RD_RISE   = RD_VALID ? w_rise[r_idx] : '0;
`endif

endmodule

// File: tb/tb_toggle_monitor_asg.sv
// Bench for toggle_monitor_asg: table vectors, hand sequences and random windows
// checked against a sample-list toggle model; a CNT_W=4 twin covers saturation.
module tb_toggle_monitor_asg;
  import toggle_monitor_asg_pkg::*;

  localparam int N  = 8;
  localparam int CW = 16;
  localparam int SW = 4;
  localparam int IW = 3;
  localparam longint SMAX = 15;

  logic          CP = 1'b0;
  logic          CDN = 1'b0;
  logic [N-1:0]  NETS = '0;
  logic          START = 1'b0;
  logic [15:0]   WIN_LEN = '0;
  logic          RD_READY = 1'b0;
  logic          BUSY, DONE, RD_VALID;
  logic [IW-1:0] RD_IDX;
  logic [CW-1:0] RD_CNT;
  state_t        DBG_STATE;
  logic          s_busy, s_done, s_valid;
  logic [IW-1:0] s_idx;
  logic [SW-1:0] s_cnt;
  state_t        s_state;
`ifdef ASG_TGL_SPLIT_EN
  logic [CW-1:0] RD_RISE;
  logic [SW-1:0] s_rise;
`endif

  toggle_monitor_asg #(.NUM_NETS(N), .CNT_W(CW), .WIN_W(16)) dut (
    .CP(CP), .CDN(CDN), .NETS(NETS), .START(START), .WIN_LEN(WIN_LEN),
    .BUSY(BUSY), .DONE(DONE), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .RD_IDX(RD_IDX), .RD_CNT(RD_CNT),
`ifdef ASG_TGL_SPLIT_EN
    .RD_RISE(RD_RISE),
`endif
    .DBG_STATE(DBG_STATE)
  );

  toggle_monitor_asg #(.NUM_NETS(N), .CNT_W(SW), .WIN_W(16)) dut_s (
    .CP(CP), .CDN(CDN), .NETS(NETS), .START(START), .WIN_LEN(WIN_LEN),
    .BUSY(s_busy), .DONE(s_done), .RD_VALID(s_valid), .RD_READY(RD_READY),
    .RD_IDX(s_idx), .RD_CNT(s_cnt),
`ifdef ASG_TGL_SPLIT_EN
    .RD_RISE(s_rise),
`endif
    .DBG_STATE(s_state)
  );

  // clock / watchdog
  always #5 CP = ~CP;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] rise_q[$];
  logic [N-1:0]  seq_q[$];

  typedef struct {
    int            win;
    logic [N-1:0]  tgl;
    logic [N-1:0]  once;
    int            mode;
    logic [CW-1:0] exp_cnt [N];
  } vec_t;
  vec_t vt[4];

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint satv(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  // Reference: count bit differences between consecutive samples in seq_q.
  task automatic build_expected();
    int tg[N];
    int rs[N];
    for (int i = 0; i < N; i++) begin
      tg[i] = 0;
      rs[i] = 0;
    end
    for (int c = 1; c < seq_q.size(); c++) begin
      for (int i = 0; i < N; i++) begin
        if (seq_q[c][i] != seq_q[c-1][i]) begin
          tg[i]++;
          if (seq_q[c][i]) rs[i]++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(CW'(satv(tg[i], 65535)));
      rise_q.push_back(CW'(satv(rs[i], 65535)));
    end
  endtask

  // driver tasks
  task automatic run_window(input int w, input bit poke);
    @(negedge CP);
    NETS = seq_q[0];
    WIN_LEN = 16'(w);
    START = 1'b1;
    @(negedge CP);
    START = 1'b0;
    check("busy_after_start", BUSY, 1);
    for (int c = 1; c <= w; c++) begin
      NETS = seq_q[c];
      if (poke && c == 2) begin
        START = 1'b1;
        WIN_LEN = 16'd2;
      end
      @(negedge CP);
      START = 1'b0;
      if (c < w) begin
        check("valid_in_count", RD_VALID, 0);
        check("busy_in_count", BUSY, 1);
      end
    end
  endtask

  task automatic drain(input int mode, input int stop_at);
    int n = 0;
    int cyc = 0;
    bit rdy;
    bit tg = 1'b0;
    while (n < stop_at && cyc < 64) begin
      check("rd_valid", RD_VALID, 1);
      check("rd_idx", RD_IDX, n);
      check("rd_cnt", RD_CNT, exp_q[0]);
      check("s_valid", s_valid, 1);
      check("s_idx", s_idx, n);
      check("s_cnt", s_cnt, satv(exp_q[0], SMAX));
      check("done_low", DONE, 0);
`ifdef ASG_TGL_SPLIT_EN
      check("rd_rise", RD_RISE, rise_q[0]);
      check("s_rise", s_rise, satv(rise_q[0], SMAX));
`endif
      case (mode)
        0: rdy = 1'b1;
        1: begin rdy = tg; tg = ~tg; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      RD_READY = rdy;
      @(negedge CP);
      cyc++;
      if (rdy) begin
        void'(exp_q.pop_front());
        void'(rise_q.pop_front());
        n++;
      end
    end
    RD_READY = 1'b0;
    if (cyc >= 64) check("drain_timeout", n, stop_at);
    if (stop_at == N && n == N) begin
      check("done_pulse", DONE, 1);
      check("s_done_pulse", s_done, 1);
      check("busy_after_drain", BUSY, 0);
      check("valid_after_drain", RD_VALID, 0);
      check("cnt_after_drain", RD_CNT, 0);
      @(negedge CP);
      check("done_clear", DONE, 0);
    end
  endtask

  task automatic rand_seq(input int w);
    logic [N-1:0] mask;
    mask = N'($urandom);
    seq_q.delete();
    for (int c = 0; c <= w; c++) seq_q.push_back(N'($urandom) & mask);
  endtask

  initial begin
    // reset state
    CDN = 1'b0;
    repeat (3) @(negedge CP);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_valid", RD_VALID, 0);
    check("rst_idx", RD_IDX, 0);
    check("rst_cnt", RD_CNT, 0);
    check("rst_state", DBG_STATE, ST_IDLE);
    check("rst_s_busy", s_busy, 0);
    CDN = 1'b1;
    @(negedge CP);

    // table vectors
    vt[0].win = 4;  vt[0].tgl = 8'h01; vt[0].once = 8'h04; vt[0].mode = 0;
    vt[1].win = 20; vt[1].tgl = 8'h08; vt[1].once = 8'h00; vt[1].mode = 1;
    vt[2].win = 0;  vt[2].tgl = 8'h00; vt[2].once = 8'h00; vt[2].mode = 0;
    vt[3].win = 7;  vt[3].tgl = 8'hF0; vt[3].once = 8'h0F; vt[3].mode = 2;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < N; i++) vt[r].exp_cnt[i] = '0;
    vt[0].exp_cnt[0] = 16'd4;
    vt[0].exp_cnt[2] = 16'd1;
    vt[1].exp_cnt[3] = 16'd20;
    for (int i = 0; i < 4; i++) vt[3].exp_cnt[i] = 16'd1;
    for (int i = 4; i < 8; i++) vt[3].exp_cnt[i] = 16'd7;

    for (int r = 0; r < 4; r++) begin
      seq_q.delete();
      seq_q.push_back('0);
      for (int c = 1; c <= vt[r].win; c++)
        seq_q.push_back(((c % 2) ? vt[r].tgl : '0) ^ ((c >= 2) ? vt[r].once : '0));
      build_expected();
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(vt[r].exp_cnt[i]);
      run_window(vt[r].win, 1'b0);
      drain(vt[r].mode, N);
    end

`ifdef ASG_TGL_SPLIT_EN
    // rise/fall split: net0 = 0,1,0,1,1 -> 2 rises, 1 fall
    seq_q.delete();
    seq_q.push_back(8'h00); seq_q.push_back(8'h01); seq_q.push_back(8'h00);
    seq_q.push_back(8'h01); seq_q.push_back(8'h01);
    exp_q.delete();
    rise_q.delete();
    exp_q.push_back(16'd3);
    rise_q.push_back(16'd2);
    for (int i = 1; i < N; i++) begin
      exp_q.push_back('0);
      rise_q.push_back('0);
    end
    run_window(4, 1'b0);
    drain(0, N);
`endif

    // START during COUNT is ignored; the original 5-cycle window runs out
    rand_seq(5);
    build_expected();
    run_window(5, 1'b1);
    drain(0, N);

    // asynchronous reset in the middle of a drain
    rand_seq(6);
    build_expected();
    run_window(6, 1'b0);
    drain(0, 3);
    check("pre_rst_idx", RD_IDX, 3);
    CDN = 1'b0;
    #1;
    check("mid_rst_valid", RD_VALID, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_idx", RD_IDX, 0);
    check("mid_rst_cnt", RD_CNT, 0);
    @(negedge CP);
    CDN = 1'b1;
    exp_q.delete();
    rise_q.delete();
    rand_seq(3);
    build_expected();
    run_window(3, 1'b0);
    drain(1, N);

    // random windows
    for (int k = 0; k < 8; k++) begin
      int w;
      w = int'($urandom_range(1, 24));
      rand_seq(w);
      build_expected();
      run_window(w, 1'b0);
      drain(int'($urandom_range(0, 2)), N);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
